// File: rtl/alu_exec_unit.sv
// Execute-stage ALU with registered result behind a valid/ready handshake.
// Single-cycle ADD/SUB/AND/OR/SLT plus an iterative shift-add MUL.
module alu_exec_unit #(
  parameter int WIDTH = 32
) (
  input  logic             clk,
  input  logic             reset,
  input  logic             in_valid,
  output logic             in_ready,
  input  logic [2:0]       ALUControl,
  input  logic [WIDTH-1:0] SrcA,
  input  logic [WIDTH-1:0] SrcB,
  output logic             out_valid,
  input  logic             out_ready,
  output logic [WIDTH-1:0] Result,
  output logic             Zero,
  output logic             illegal,
  output logic             busy
);

  localparam int CW = $clog2(WIDTH);

  typedef enum logic [1:0] {
    IDLE = 2'd0,
    MUL  = 2'd1,
    HOLD = 2'd2
  } state_e;

  state_e           state_q, state_d;
  logic             ov_q, ov_d;
  logic [WIDTH-1:0] res_q, res_d;
  logic             zero_q, zero_d;
  logic             ill_q, ill_d;
  logic             busy_q, busy_d;
  logic [WIDTH-1:0] mcand_q, mcand_d;
  logic [WIDTH-1:0] mplier_q, mplier_d;
  logic [WIDTH-1:0] acc_q, acc_d;
  logic [CW-1:0]    cnt_q, cnt_d;

  logic [WIDTH-1:0] alu_res;
  logic             alu_ill;
  logic [WIDTH-1:0] acc_sum;
  logic             accept;
  logic             last_it;

  // Single-cycle datapath; anything not a known code reads as illegal.
  always_comb begin
    alu_res = '0;
    alu_ill = 1'b0;
    case (ALUControl)
      3'b000:  alu_res = SrcA + SrcB;
      3'b001:  alu_res = SrcA - SrcB;
      3'b010:  alu_res = SrcA & SrcB;
      3'b011:  alu_res = SrcA | SrcB;
      3'b101:  alu_res = {{(WIDTH-1){1'b0}},
                          ($signed(SrcA) < $signed(SrcB))};
      default: alu_ill = 1'b1;
    endcase
  end

  // Handshake, FSM next state and shift-add iteration.
  always_comb begin
    state_d  = state_q;
    ov_d     = ov_q;
    res_d    = res_q;
    zero_d   = zero_q;
    ill_d    = ill_q;
    busy_d   = busy_q;
    mcand_d  = mcand_q;
    mplier_d = mplier_q;
    acc_d    = acc_q;
    cnt_d    = cnt_q;
    in_ready = (state_q == IDLE) && (!ov_q || out_ready);
    accept   = in_valid && in_ready;
    acc_sum  = acc_q + (mplier_q[0] ? mcand_q : '0);
    last_it  = (cnt_q == CW'(WIDTH-1));
    case (state_q)
      IDLE: begin
        if (ov_q && out_ready) ov_d = 1'b0;
        if (accept) begin
          if (ALUControl == 3'b100) begin
            mcand_d  = SrcA;
            mplier_d = SrcB;
            acc_d    = '0;
            cnt_d    = '0;
            busy_d   = 1'b1;
            state_d  = MUL;
          end else begin
            res_d  = alu_res;
            zero_d = (alu_res == '0);
            ill_d  = alu_ill;
            ov_d   = 1'b1;
          end
        end
      end
      MUL: begin
        acc_d    = acc_sum;
        mcand_d  = mcand_q << 1;
        mplier_d = mplier_q >> 1;
        cnt_d    = cnt_q + 1'b1;
        if (last_it) begin
          res_d   = acc_sum;
          zero_d  = (acc_sum == '0);
          ill_d   = 1'b0;
          ov_d    = 1'b1;
          busy_d  = 1'b0;
          cnt_d   = '0;
          state_d = HOLD;
        end
      end
      HOLD: begin
        if (out_ready) begin
          ov_d    = 1'b0;
          state_d = IDLE;
        end
      end
      default: state_d = IDLE;
    endcase
  end

  // State and result registers; reset discards any MUL in flight.
  always_ff @(posedge clk) begin
    if (reset) begin
      state_q  <= IDLE;
      ov_q     <= 1'b0;
      res_q    <= '0;
      zero_q   <= 1'b1;
      ill_q    <= 1'b0;
      busy_q   <= 1'b0;
      mcand_q  <= '0;
      mplier_q <= '0;
      acc_q    <= '0;
      cnt_q    <= '0;
    end else begin
      state_q  <= state_d;
      ov_q     <= ov_d;
      res_q    <= res_d;
      zero_q   <= zero_d;
      ill_q    <= ill_d;
      busy_q   <= busy_d;
      mcand_q  <= mcand_d;
      mplier_q <= mplier_d;
      acc_q    <= acc_d;
      cnt_q    <= cnt_d;
    end
  end

  assign out_valid = ov_q;
  assign Result    = res_q;
  assign Zero      = zero_q;
  assign illegal   = ill_q;
  assign busy      = busy_q;

endmodule

// File: tb/tb_alu_exec_unit.sv
// Scoreboard bench for alu_exec_unit.
// Stimulus pushes model results; a monitor pops on each output handshake.
module tb_alu_exec_unit;

  localparam int W = 32;

  logic         clk = 1'b0;
  logic         reset;
  logic         in_valid;
  logic         in_ready;
  logic [2:0]   ALUControl;
  logic [W-1:0] SrcA;
  logic [W-1:0] SrcB;
  logic         out_valid;
  logic         out_ready;
  logic [W-1:0] Result;
  logic         Zero;
  logic         illegal;
  logic         busy;

  int tests = 0;
  int fails = 0;

  typedef struct {
    logic [W-1:0] r;
    logic         z;
    logic         il;
  } exp_t;

  exp_t sb[$];

  alu_exec_unit #(.WIDTH(W)) dut (
    .clk(clk),
    .reset(reset),
    .in_valid(in_valid),
    .in_ready(in_ready),
    .ALUControl(ALUControl),
    .SrcA(SrcA),
    .SrcB(SrcB),
    .out_valid(out_valid),
    .out_ready(out_ready),
    .Result(Result),
    .Zero(Zero),
    .illegal(illegal),
    .busy(busy)
  );

  always #5 clk = ~clk;

  function automatic exp_t model(input logic [2:0] op,
                                 input logic [W-1:0] a,
                                 input logic [W-1:0] b);
    exp_t e;
    longint unsigned p;
    e.il = 1'b0;
    e.r  = '0;
    case (op)
      3'd0: e.r = a + b;
      3'd1: e.r = a - b;
      3'd2: e.r = a & b;
      3'd3: e.r = a | b;
      3'd4: begin
        p   = longint'(a) * longint'(b);
        e.r = p[W-1:0];
      end
      3'd5: e.r = ($signed(a) < $signed(b)) ? 1 : 0;
      default: e.il = 1'b1;
    endcase
    e.z = (e.r == 0);
    return e;
  endfunction

  task automatic chk(input string name,
                     input logic [W-1:0] act,
                     input logic [W-1:0] exp);
    tests++;
    if (act !== exp) begin
      fails++;
      $display("FAIL %s: got %h expected %h", name, act, exp);
    end
  endtask

  // Monitor: every output transfer is compared against the queue head.
  initial begin
    exp_t e;
    forever begin
      @(negedge clk);
      if (!reset && out_valid && out_ready) begin
        tests++;
        if (sb.size() == 0) begin
          fails++;
          $display("FAIL unexpected_out: got %h with empty scoreboard",
                   Result);
        end else begin
          e = sb.pop_front();
          if (Result !== e.r || Zero !== e.z || illegal !== e.il) begin
            fails++;
            $display("FAIL result: got r=%h z=%b il=%b expected r=%h z=%b il=%b",
                     Result, Zero, illegal, e.r, e.z, e.il);
          end
        end
      end
    end
  end

  task automatic issue(input logic [2:0] op,
                       input logic [W-1:0] a,
                       input logic [W-1:0] b,
                       input bit rnd_ready);
    bit done = 0;
    in_valid   = 1'b1;
    ALUControl = op;
    SrcA       = a;
    SrcB       = b;
    for (int k = 0; k < 200; k++) begin
      @(negedge clk);
      if (in_ready) begin
        sb.push_back(model(op, a, b));
        done = 1;
      end
      @(posedge clk);
      #1;
      if (rnd_ready) out_ready = ($urandom_range(0, 3) != 0);
      if (done) break;
    end
    in_valid = 1'b0;
    if (!done) begin
      tests++;
      fails++;
      $display("FAIL issue_timeout: op %0d never accepted", op);
    end
  endtask

  task automatic drain();
    int n = 0;
    out_ready = 1'b1;
    while (sb.size() != 0 && n < 200) begin
      @(posedge clk);
      #1;
      n++;
    end
    repeat (2) @(posedge clk);
    #1;
    chk("drain_empty", W'(sb.size()), 0);
  endtask

  function automatic logic [W-1:0] rnd_op();
    case ($urandom_range(0, 7))
      0: return '0;
      1: return 1;
      2: return '1;
      3: return 32'h8000_0000;
      4: return 32'h7FFF_FFFF;
      default: return $urandom;
    endcase
  endfunction

  initial begin
    int n;
    reset      = 1'b1;
    in_valid   = 1'b0;
    out_ready  = 1'b0;
    ALUControl = 3'd0;
    SrcA       = '0;
    SrcB       = '0;
    repeat (2) @(posedge clk);
    #1;
    chk("rst_out_valid", W'(out_valid), 0);
    chk("rst_result", Result, 0);
    chk("rst_zero", W'(Zero), 1);
    chk("rst_illegal", W'(illegal), 0);
    chk("rst_busy", W'(busy), 0);
    reset = 1'b0;
    #1;
    chk("idle_in_ready", W'(in_ready), 1);

    out_ready = 1'b1;
    issue(3'd0, 5, 7, 0);
    chk("add_latency", W'(out_valid), 1);
    chk("add_result", Result, 12);
    issue(3'd1, 3, 3, 0);
    chk("sub_zero", W'(Zero), 1);
    issue(3'd1, 0, 1, 0);
    chk("sub_wrap", Result, 32'hFFFF_FFFF);
    issue(3'd5, 32'hFFFF_FFFE, 1, 0);
    chk("slt_neg", Result, 1);
    issue(3'd5, 1, 32'hFFFF_FFFE, 0);
    chk("slt_pos", Result, 0);
    drain();

    issue(3'd4, 32'h0001_0003, 32'h0000_0005, 0);
    chk("mul_busy", W'(busy), 1);
    chk("mul_in_ready", W'(in_ready), 0);
    n = 0;
    while (!out_valid && n < 100) begin
      @(posedge clk);
      #1;
      n++;
    end
    chk("mul_latency", W'(n + 1), W + 1);
    chk("mul_result", Result, 32'h0005_000F);
    chk("mul_busy_done", W'(busy), 0);
    issue(3'd4, 32'hFFFF_FFFF, 32'hFFFF_FFFF, 0);
    drain();

    out_ready = 1'b0;
    issue(3'd0, 1, 1, 0);
    repeat (10) begin
      @(negedge clk);
      chk("bp_result", Result, 2);
      chk("bp_in_ready", W'(in_ready), 0);
    end
    @(posedge clk);
    #1;
    out_ready = 1'b1;
    issue(3'd3, 4, 8, 0);
    chk("bp_replace", Result, 12);
    drain();

    issue(3'd4, 32'h1234_5678, 32'h0000_0F0F, 0);
    repeat (9) @(posedge clk);
    #1;
    reset = 1'b1;
    @(posedge clk);
    #1;
    reset = 1'b0;
    if (sb.size() != 0) void'(sb.pop_back());
    chk("rst_mul_valid", W'(out_valid), 0);
    chk("rst_mul_busy", W'(busy), 0);
    chk("rst_mul_result", Result, 0);
    chk("rst_mul_ready", W'(in_ready), 1);
    repeat (40) @(posedge clk);
    #1;
    chk("rst_mul_no_out", W'(out_valid), 0);

    issue(3'd6, 32'd123, 32'd456, 0);
    chk("illegal_flag", W'(illegal), 1);
    chk("illegal_result", Result, 0);
    issue(3'd0, 2, 2, 0);
    chk("illegal_clear", W'(illegal), 0);
    drain();

    for (int i = 0; i < 300; i++) begin
      issue(3'($urandom_range(0, 7)), rnd_op(), rnd_op(), 1);
      if ($urandom_range(0, 3) == 0) begin
        @(posedge clk);
        #1;
        out_ready = ($urandom_range(0, 1) != 0);
      end
    end
    drain();

    $display("[TB] %0d tests run, %0d failed", tests, fails);
    $finish;
  end

endmodule
